// File: rtl/prn_free_sequencer.sv
// prn_free_sequencer: seeds the renamer free list at reset, then forwards ROB frees
// compacted onto the lowest lanes, dropping illegal or duplicate frees via an in-free bitmap.
module prn_free_sequencer #(
    parameter int PRN_BITS       = 6,
    parameter int MAX_OPERANDS   = 3,
    parameter int FIRST_SEED_PRN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MAX_OPERANDS-1:0] rob_free_valid,
    input  logic [PRN_BITS-1:0]     rob_free_prns [MAX_OPERANDS],
    output logic                    rob_free_ready,
    input  logic [MAX_OPERANDS-1:0] alloc_valid,
    input  logic [PRN_BITS-1:0]     alloc_prns [MAX_OPERANDS],
    output logic [MAX_OPERANDS-1:0] free_valid,
    output logic [PRN_BITS-1:0]     free_prns [MAX_OPERANDS],
    output logic                    rename_enable,
    output logic                    seed_done,
    output logic                    free_error,
    output logic [PRN_BITS-1:0]     free_error_prn
);
    localparam int NP = 1 << PRN_BITS;
    localparam int CW = PRN_BITS + 1;
    localparam int IW = MAX_OPERANDS > 1 ? $clog2(MAX_OPERANDS) : 1;
    localparam logic [CW-1:0] LAST  = {1'b0, {PRN_BITS{1'b1}}} - 1'b1;
    localparam logic [CW-1:0] FIRST = FIRST_SEED_PRN[CW-1:0];

    typedef enum logic {SEED, RUN} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           seed_cnt, seed_n, s;
    logic [NP-1:0]           in_free, in_free_n;
    logic [MAX_OPERANDS-1:0] fv_n;
    logic [PRN_BITS-1:0]     fp_n [MAX_OPERANDS];
    logic [PRN_BITS-1:0]     p;
    logic [IW:0]             cnt;
    logic                    err_hit;
    logic [PRN_BITS-1:0]     err_prn_n;

    assign rob_free_ready = state == RUN;
    assign rename_enable  = state == RUN;
    assign seed_done      = state == RUN;

    always_comb begin
        in_free_n = in_free;
        fv_n      = '0;
        fp_n      = '{default: '0};
        state_n   = state;
        seed_n    = seed_cnt;
        cnt       = '0;
        err_hit   = 1'b0;
        err_prn_n = '0;
        s         = '0;
        p         = '0;
        // Allocations clear first so a same-cycle realloc+free of one PRN is legal
        for (int i = 0; i < MAX_OPERANDS; i++)
            if (alloc_valid[i]) in_free_n[alloc_prns[i]] = 1'b0;
        if (state == SEED) begin
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                s = seed_cnt + CW'(i);
                if (s <= LAST) begin
                    fv_n[i]   = 1'b1;
                    fp_n[i]   = s[PRN_BITS-1:0];
                    in_free_n[s[PRN_BITS-1:0]] = 1'b1;
                    seed_n    = s + 1'b1;
                end
            end
            state_n = seed_cnt > LAST ? RUN : SEED;
        end else begin
            // Earlier lanes' pushes mark the bitmap, so repeats within a cycle read as duplicates
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                p = rob_free_prns[i];
                if (rob_free_valid[i]) begin
                    if (p == '0 || p == '1 || in_free_n[p]) begin
                        err_prn_n = err_hit ? err_prn_n : p;
                        err_hit   = 1'b1;
                    end else begin
                        fv_n[cnt[IW-1:0]] = 1'b1;
                        fp_n[cnt[IW-1:0]] = p;
                        in_free_n[p]      = 1'b1;
                        cnt               = cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= SEED;
            seed_cnt       <= FIRST;
            in_free        <= '0;
            free_valid     <= '0;
            free_prns      <= '{default: '0};
            free_error     <= 1'b0;
            free_error_prn <= '0;
        end else begin
            state      <= state_n;
            seed_cnt   <= seed_n;
            in_free    <= in_free_n;
            free_valid <= fv_n;
            free_prns  <= fp_n;
            if (err_hit && !free_error) begin
                free_error     <= 1'b1;
                free_error_prn <= err_prn_n;
            end
        end
    end
endmodule

// File: doc/prn_free_sequencer.md
PRN_FREE_SEQUENCER -- requirements
Module: prn_free_sequencer

Interface
REQ-001 Parameter PRN_BITS, default 6, physical register number width.
REQ-002 Parameter MAX_OPERANDS, default 3, free/alloc lanes per cycle.
REQ-003 Parameter FIRST_SEED_PRN, default 1, lowest PRN seeded; PRN 0 (zero) and PRN 2^PRN_BITS-1 (invalid) are never seeded or freed.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rob_free_valid  in  1[MAX_OPERANDS]  ROB retiring a PRN on lane i.
REQ-007 rob_free_prns  in  PRN_BITS[MAX_OPERANDS]  PRN retired on lane i.
REQ-008 rob_free_ready  out  1  ROB retire lanes accepted this cycle.
REQ-009 alloc_valid  in  1[MAX_OPERANDS]  renamer popped a PRN on lane i (renamer prn_output_valid).
REQ-010 alloc_prns  in  PRN_BITS[MAX_OPERANDS]  PRN popped on lane i.
REQ-011 free_valid  out  1[MAX_OPERANDS]  push-enable to renamer free list, lane i.
REQ-012 free_prns  out  PRN_BITS[MAX_OPERANDS]  PRN pushed on lane i.
REQ-013 rename_enable  out  1  renamer may accept instructions (gates its input_valid).
REQ-014 seed_done  out  1  initial seeding complete.
REQ-015 free_error  out  1  sticky: illegal or duplicate free seen.
REQ-016 free_error_prn  out  PRN_BITS  PRN of first illegal/duplicate free.

Function
REQ-017 States: SEED, RUN; RUN is terminal until reset.
REQ-018 SEED: each cycle drive lanes 0..k-1 with the next k consecutive PRNs ascending from FIRST_SEED_PRN, k = min(MAX_OPERANDS, remaining); last seeded PRN is 2^PRN_BITS-2.
REQ-019 Defaults: 62 PRNs in 21 SEED cycles (20 x3, final x2, lane 2 invalid); transition to RUN on the cycle after the final seed push.
REQ-020 In SEED: rob_free_ready=0, rename_enable=0, seed_done=0; ROB lanes are ignored.
REQ-021 In RUN: rob_free_ready=1, rename_enable=1, seed_done=1.
REQ-022 Outputs free_valid/free_prns are registered; ROB free accepted at edge N appears on free_* in cycle N+1 (1-cycle latency).
REQ-023 Compaction: accepted valid ROB lanes map to lowest output lanes in ascending input-lane order, no gaps; unused lanes have free_valid=0 and free_prns=0.
REQ-024 Tracking bitmap in_free[2^PRN_BITS]: bit set when PRN is pushed (seed or RUN free), cleared when alloc_valid lane names it.
REQ-025 Alloc lanes update the bitmap in every state; an alloc and free of the same PRN in one cycle: free judged against bitmap after the alloc clear (legal).
REQ-026 Illegal free: PRN 0, PRN 2^PRN_BITS-1, PRN with in_free already set, or same PRN on two valid lanes in one cycle (second and later occurrences) -- lane dropped, not pushed, bitmap unchanged.
REQ-027 First illegal free sets free_error=1 and latches free_error_prn; later errors do not overwrite; cleared only by reset.
REQ-028 Legal frees are never dropped; throughput is MAX_OPERANDS per cycle, so no internal queue beyond the output register.
REQ-029 Seed counter width PRN_BITS+1; no wrap past 2^PRN_BITS-2.

Reset
REQ-030 On rst assertion, asynchronously: state=SEED, seed counter=FIRST_SEED_PRN, in_free all 0, free_valid all 0, free_prns 0, rob_free_ready=0, rename_enable=0, seed_done=0, free_error=0, free_error_prn=0.
REQ-031 Reset mid-SEED or mid-RUN aborts; in-flight output-register pushes are discarded; seeding restarts from FIRST_SEED_PRN on first edge after deassert.
REQ-032 Renamer must be reset by the same rst so its free list is empty when seeding restarts.

Verification
REQ-033 Release reset -> cycles 1..20 push {1,2,3}..{58,59,60}, cycle 21 pushes {61,62,-}, seed_done=1 and rename_enable=1 from cycle 22.
REQ-034 RUN, alloc PRNs 5,9,12; next cycle free valid={0,1,1} prns {x,9,12} -> next cycle free_valid={1,1,0} prns {9,12,0}.
REQ-035 RUN, free PRN 7 (still in_free) -> no push, free_error=1, free_error_prn=7; later free of 63 leaves free_error_prn=7.
REQ-036 RUN, same cycle alloc 20 and free 20 -> 20 pushed next cycle, no error.
REQ-037 Free lanes both carrying allocated PRN 30 -> single push of 30, error latched with 30.
REQ-038 Assert rst during SEED cycle 10 -> outputs zero immediately; after release, seeding restarts with {1,2,3}; ROB valid during SEED ignored, rob_free_ready=0.
